// File: rtl/coreriscv_axi4_alu_arbiter.sv
// ---------------------------------------------------------------------------
// coreriscv_axi4_alu_arbiter
//
// Purpose
//   Two-requester arbiter and sequencer for the shared CoreRISCV integer ALU.
//   Port 0 is the pipeline execute stage, port 1 is the CSR/debug unit.
//   An accepted request is latched into operand registers that drive the
//   shared ALU directly. One cycle later the ALU outputs are captured into
//   the response registers and presented with the requester id.
//
// Handshake rules (request and response channels)
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A requester holds valid and its payload stable until it is accepted.
//   resp_valid and resp_* stay stable until resp_ready is seen high.
//   Ready is a combinational function of state, the valids, the arbitration
//   pointer and resp_ready. No resp_* data depends combinationally on
//   resp_ready.
//
// Configuration
//   CORERISCV_AXI4_ALU_ARB_RR_EN
//     Defined:   a tie is resolved round-robin. The pointer records the
//                last granted port and gives the tie to the other port.
//     Undefined: fixed priority. Port 0 always wins a tie and there is no
//                pointer.
//
// Ports
//   clk, reset                     core clock, synchronous active-low reset
//   req{0,1}_valid/_ready          request handshake per port
//   req{0,1}_fn/_dw/_in1/_in2      ALU function, width select and operands
//   resp_valid/resp_ready          response handshake
//   resp_id                        requester that owns the current result
//   resp_out/_adder_out/_cmp_out   registered ALU results
//   alu_fn/_dw/_in1/_in2           drive the shared ALU (operand registers)
//   alu_out/_adder_out/_cmp_out    results from the shared ALU
//   dbg_state                      current FSM state (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module coreriscv_axi4_alu_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_fn,
  input  logic        req0_dw,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_fn,
  input  logic        req1_dw,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_out,
  output logic [31:0] resp_adder_out,
  output logic        resp_cmp_out,

  output logic [3:0]  alu_fn,
  output logic        alu_dw,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_adder_out,
  input  logic        alu_cmp_out,

  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;

  // Operand registers: the only source of the ALU inputs.
  logic        op_id;
  logic [3:0]  op_fn;
  logic        op_dw;
  logic [31:0] op_in1;
  logic [31:0] op_in2;

  logic        accept_window;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        tie_to_port1;

`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
  // 1 means port 1 was granted last. It resets to 1 so port 0 wins the
  // first tie after reset.
  logic        rr_last;

  assign tie_to_port1 = ~rr_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant1;
    end
  end
`else
  assign tie_to_port1 = 1'b0;
`endif

  // A new request can be taken when idle, or when the current response
  // leaves this cycle. Gating with reset keeps both readies low while
  // reset is asserted.
  always_comb begin
    accept_window = 1'b0;
    grant0        = 1'b0;
    grant1        = 1'b0;
    if (reset) begin
      accept_window = (state == ST_IDLE) ||
                      ((state == ST_RESP) && resp_ready);
    end
    if (accept_window) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~tie_to_port1;
        grant1 = tie_to_port1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The ALU always sees the operand registers. Its inputs change only
  // when a request is accepted, so the result captured in EXEC belongs
  // to the operation latched on the previous edge.
  assign alu_fn  = op_fn;
  assign alu_dw  = op_dw;
  assign alu_in1 = op_in1;
  assign alu_in2 = op_in2;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_id  <= 1'b0;
      op_fn  <= 4'd0;
      op_dw  <= 1'b0;
      op_in1 <= 32'd0;
      op_in2 <= 32'd0;
    end else if (accept) begin
      op_id  <= grant1;
      op_fn  <= grant1 ? req1_fn  : req0_fn;
      op_dw  <= grant1 ? req1_dw  : req0_dw;
      op_in1 <= grant1 ? req1_in1 : req0_in1;
      op_in2 <= grant1 ? req1_in2 : req0_in2;
    end
  end

  // Sequencer. resp_valid and the resp_* data are registered outputs.
  // A reset in EXEC or RESP drops the in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_out       <= 32'd0;
      resp_adder_out <= 32'd0;
      resp_cmp_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_id        <= op_id;
          resp_out       <= alu_out;
          resp_adder_out <= alu_adder_out;
          resp_cmp_out   <= alu_cmp_out;
          resp_valid     <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          // While resp_ready is low, everything holds. When the response
          // leaves, a request taken in the same cycle goes straight to EXEC.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coreriscv_axi4_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coreriscv_axi4_alu_arbiter
//
// Self-checking bench for coreriscv_axi4_alu_arbiter.
//
// The bench provides a behavioural model of the shared ALU. A transaction
// model tracks the in-flight operation, the expected response queue and
// the tie rule. It checks every DUT output on each falling edge.
// Directed cases pin the model to hand-computed values.
//
// Define CORERISCV_AXI4_ALU_ARB_RR_EN to check the round-robin build.
// ---------------------------------------------------------------------------
module tb_coreriscv_axi4_alu_arbiter;

  localparam int W = 66;  // {id, cmp, adder[31:0], out[31:0]}

  typedef struct packed {
    logic [3:0]  fn;
    logic        dw;
    logic [31:0] in1;
    logic [31:0] in2;
  } req_t;

  // ---------------- clock / reset ----------------
  bit          clk;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0;
  logic [3:0]  req0_fn    = '0;
  logic        req0_dw    = 1'b0;
  logic [31:0] req0_in1   = '0;
  logic [31:0] req0_in2   = '0;
  logic        req1_valid = 1'b0;
  logic [3:0]  req1_fn    = '0;
  logic        req1_dw    = 1'b0;
  logic [31:0] req1_in1   = '0;
  logic [31:0] req1_in2   = '0;
  logic        resp_ready = 1'b0;

  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_cmp_out;
  logic [31:0] resp_out, resp_adder_out;
  logic [3:0]  alu_fn;
  logic        alu_dw;
  logic [31:0] alu_in1, alu_in2;
  logic [31:0] alu_out, alu_adder_out;
  logic        alu_cmp_out;
  logic [1:0]  dbg_state;

  coreriscv_axi4_alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn),
    .req0_dw(req0_dw), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn),
    .req1_dw(req1_dw), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_adder_out(resp_adder_out),
    .resp_cmp_out(resp_cmp_out),
    .alu_fn(alu_fn), .alu_dw(alu_dw), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_adder_out(alu_adder_out),
    .alu_cmp_out(alu_cmp_out),
    .dbg_state(dbg_state)
  );

  // ---------------- shared ALU model: {cmp, adder, out} ----------------
  function automatic logic [64:0] alu_f(input logic [3:0] fn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] add;
    logic [31:0] o;
    logic        c;
    add = fn[3] ? (a - b) : (a + b);
    case (fn)
      4'h2:    c = (a == b);
      4'h3:    c = (a != b);
      4'hC:    c = ($signed(a) <  $signed(b));
      4'hD:    c = ($signed(a) >= $signed(b));
      4'hE:    c = (a <  b);
      4'hF:    c = (a >= b);
      default: c = 1'b0;
    endcase
    case (fn)
      4'h0, 4'hA:                      o = add;
      4'h1:                            o = a << b[4:0];
      4'h2, 4'h3, 4'hC, 4'hD, 4'hE, 4'hF: o = {31'd0, c};
      4'h4:                            o = a ^ b;
      4'h5:                            o = a >> b[4:0];
      4'h6:                            o = a | b;
      4'h7:                            o = a & b;
      4'hB:                            o = $signed(a) >>> b[4:0];
      default:                         o = 32'd0;
    endcase
    return {c, add, o};
  endfunction

  assign {alu_cmp_out, alu_adder_out, alu_out} = alu_f(alu_fn, alu_in1, alu_in2);

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  req_t q0[$];
  req_t q1[$];
  int   acc0_n = 0, acc1_n = 0;  // acceptances seen at the DUT
  int   pop0_n = 0, pop1_n = 0;

  always @(posedge clk) begin
    #2;
    while (pop0_n < acc0_n) begin void'(q0.pop_front()); pop0_n++; end
    while (pop1_n < acc1_n) begin void'(q1.pop_front()); pop1_n++; end
    req0_valid = (q0.size() != 0);
    if (q0.size() != 0) {req0_fn, req0_dw, req0_in1, req0_in2} = q0[0];
    req1_valid = (q1.size() != 0);
    if (q1.size() != 0) {req1_fn, req1_dw, req1_in1, req1_in2} = q1[0];
  end

  function automatic req_t mk(input logic [3:0] fn, input logic dw,
                              input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.fn = fn; r.dw = dw; r.in1 = a; r.in2 = b;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom, $urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor + transaction model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit    m_busy = 0, m_done = 0, m_rst = 1;
`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
  bit    m_last = 1;
`endif
  req_t  m_opr = '0;
  int    cyc = 0, acc0_cyc = 0, acc1_cyc = 0, hs_cyc = 0, rise_cyc = 0;
  logic  prev_rv = 1'b0;
  bit    hold0 = 0, hold1 = 0;
  req_t  hold0_pl, hold1_pl;

  always @(negedge clk) begin
    bit open, e0, e1;
    logic [W-1:0] head;
    cyc++;

    // requester protocol: no withdrawal or payload change before acceptance
    if (hold0 && reset)
      assert (req0_valid && {req0_fn, req0_dw, req0_in1, req0_in2} == hold0_pl)
        else $error("port 0 request withdrawn before acceptance");
    if (hold1 && reset)
      assert (req1_valid && {req1_fn, req1_dw, req1_in1, req1_in2} == hold1_pl)
        else $error("port 1 request withdrawn before acceptance");
    hold0 = req0_valid && !(req0_ready && reset);
    hold1 = req1_valid && !(req1_ready && reset);
    hold0_pl = {req0_fn, req0_dw, req0_in1, req0_in2};
    hold1_pl = {req1_fn, req1_dw, req1_in1, req1_in2};

    // log of what the DUT actually did (drives the driver and directed checks)
    if (reset && req0_valid && req0_ready) begin acc0_n++; acc0_cyc = cyc; end
    if (reset && req1_valid && req1_ready) begin acc1_n++; acc1_cyc = cyc; end
    if (reset && resp_valid && resp_ready) begin
      got_q.push_back({resp_id, resp_cmp_out, resp_adder_out, resp_out});
      hs_cyc = cyc;
    end
    if (resp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = resp_valid;

    // expected grant for the coming edge
    open = reset && (!m_busy || (m_done && resp_ready));
    e0 = 0;
    e1 = 0;
    if (open) begin
      if (req0_valid && req1_valid) begin
`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
        if (m_last) e0 = 1; else e1 = 1;
`else
        e0 = 1;
`endif
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end

    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("resp_valid", 64'(resp_valid), 64'(m_busy && m_done));
    if (m_busy && m_done) begin
      if (exp_q.size() != 0) head = exp_q[0];
      else head = 'x;
      chk("resp_id",        64'(resp_id),        64'(head[65]));
      chk("resp_cmp_out",   64'(resp_cmp_out),   64'(head[64]));
      chk("resp_adder_out", 64'(resp_adder_out), 64'(head[63:32]));
      chk("resp_out",       64'(resp_out),       64'(head[31:0]));
    end
    chk("alu_fn",  64'(alu_fn),  64'(m_opr.fn));
    chk("alu_dw",  64'(alu_dw),  64'(m_opr.dw));
    chk("alu_in1", 64'(alu_in1), 64'(m_opr.in1));
    chk("alu_in2", 64'(alu_in2), 64'(m_opr.in2));
    if (m_rst) begin
      chk("rst_resp_id",    64'(resp_id),        64'd0);
      chk("rst_resp_out",   64'(resp_out),       64'd0);
      chk("rst_resp_adder", 64'(resp_adder_out), 64'd0);
      chk("rst_resp_cmp",   64'(resp_cmp_out),   64'd0);
    end
    chk("dbg_state_legal", 64'(dbg_state != 2'd3), 64'd1);

    // advance the model across the coming edge
    if (!reset) begin
      m_busy = 0;
      m_done = 0;
      m_rst  = 1;
      m_opr  = '0;
`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
      m_last = 1;
`endif
      exp_q.delete();
    end else begin
      m_rst = 0;
      if (m_busy && !m_done) begin
        m_done = 1;
      end else if (m_busy && m_done && resp_ready) begin
        m_busy = 0;
        void'(exp_q.pop_front());
      end
      if (e0 || e1) begin
        m_opr = e1 ? req_t'({req1_fn, req1_dw, req1_in1, req1_in2})
                   : req_t'({req0_fn, req0_dw, req0_in1, req0_in2});
        exp_q.push_back({e1, alu_f(m_opr.fn, m_opr.in1, m_opr.in2)});
        m_busy = 1;
        m_done = 0;
`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
        m_last = e1;
`endif
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic [W-1:0] got(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 'x;
  endfunction

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin tick(); k++; end
    chk("resp_count", 64'(got_q.size()), 64'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] g;
    logic [31:0]  a, b, c, d;
    int           k, n0, nb, hs_a, acc_a;

    resp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_hold_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_hold_alu_in1",    64'(alu_in1),    64'd0);
    reset = 1'b1;
    tick();

    // add on port 0, latency 2
    q0.push_back(mk(4'h0, 1'b0, 32'd5, 32'd7));
    wait_got(1);
    g = got(0);
    chk("add_id",      64'(g[65]),    64'd0);
    chk("add_out",     64'(g[31:0]),  64'd12);
    chk("add_latency", 64'(rise_cyc - acc0_cyc), 64'd2);

    // sub on port 1
    q1.push_back(mk(4'hA, 1'b1, 32'd3, 32'd5));
    wait_got(2);
    g = got(1);
    chk("sub_id",    64'(g[65]),    64'd1);
    chk("sub_out",   64'(g[31:0]),  64'hFFFF_FFFE);
    chk("sub_adder", 64'(g[63:32]), 64'hFFFF_FFFE);

    // arithmetic shift and signed compare
    q0.push_back(mk(4'hB, 1'b0, 32'h8000_0000, 32'd4));
    q0.push_back(mk(4'hC, 1'b0, 32'hFFFF_FFFF, 32'd1));
    wait_got(4);
    g = got(2);
    chk("sra_out", 64'(g[31:0]), 64'hF800_0000);
    g = got(3);
    chk("slt_cmp", 64'(g[64]),   64'd1);
    chk("slt_out", 64'(g[31:0]), 64'd1);

    // port 1 op so the next tie starts from "port 1 granted last"
    q1.push_back(mk(4'h6, 1'b0, 32'h0000_1200, 32'h0000_0034));
    wait_got(5);
    g = got(4);
    chk("or_out", 64'(g[31:0]), 64'h1234);

    // both ports valid continuously
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    wait_got(13);
    for (int i = 0; i < 4; i++) begin
      g = got(5 + i);
`ifdef CORERISCV_AXI4_ALU_ARB_RR_EN
      chk("grant_order", 64'(g[65]), 64'(i % 2));
`else
      chk("grant_order", 64'(g[65]), 64'd0);
`endif
    end
`ifndef CORERISCV_AXI4_ALU_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      g = got(9 + i);
      chk("starved_port_after", 64'(g[65]), 64'd1);
    end
`endif

    // response back-pressure, then same-cycle acceptance
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    resp_ready = 1'b0;
    q0.push_back(mk(4'h4, 1'b0, a, b));
    k = 0;
    while (!resp_valid && k < 20) begin tick(); k++; end
    chk("hold_resp_seen", 64'(resp_valid), 64'd1);
    q1.push_back(mk(4'h7, 1'b1, c, d));
    repeat (5) tick();
    chk("hold_req1_valid", 64'(req1_valid), 64'd1);
    chk("hold_req1_ready", 64'(req1_ready), 64'd0);
    chk("hold_req0_ready", 64'(req0_ready), 64'd0);
    chk("hold_resp_out",   64'(resp_out),   64'(a ^ b));
    resp_ready = 1'b1;
    wait_got(14);
    hs_a  = hs_cyc;
    acc_a = acc1_cyc;
    chk("same_cycle_accept", 64'(acc_a), 64'(hs_a));
    g = got(13);
    chk("xor_out", 64'(g[31:0]), 64'(a ^ b));
    wait_got(15);
    chk("back_to_back_latency", 64'(rise_cyc - acc_a), 64'd2);
    g = got(14);
    chk("and_id",  64'(g[65]),   64'd1);
    chk("and_out", 64'(g[31:0]), 64'(c & d));

    // randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    resp_ready = 1'b1;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_busy) && k < 400) begin
      tick();
      k++;
    end
    chk("drain_left", 64'(q0.size() + q1.size() + int'(m_busy)), 64'd0);

    // reset while an operation is in EXEC
    nb = got_q.size();
    n0 = acc0_n;
    q0.push_back(mk(4'h0, 1'b0, 32'd100, 32'd200));
    k = 0;
    while (acc0_n == n0 && k < 50) begin @(negedge clk); #1; k++; end
    chk("rst_test_accept", 64'(acc0_n - n0), 64'd1);
    tick();                       // now in EXEC
    reset = 1'b0;
    q1.push_back(mk(4'h7, 1'b0, 32'h0000_F0F0, 32'h0000_FF00));
    tick();
    chk("rst_exec_resp_valid", 64'(resp_valid),     64'd0);
    chk("rst_exec_resp_out",   64'(resp_out),       64'd0);
    chk("rst_exec_resp_adder", 64'(resp_adder_out), 64'd0);
    chk("rst_exec_resp_id",    64'(resp_id),        64'd0);
    chk("rst_exec_alu_in1",    64'(alu_in1),        64'd0);
    chk("rst_exec_alu_fn",     64'(alu_fn),         64'd0);
    chk("rst_exec_req1_ready", 64'(req1_ready),     64'd0);
    tick();
    reset = 1'b1;
    wait_got(nb + 1);
    g = got(nb);
    chk("post_rst_id",  64'(g[65]),   64'd1);
    chk("post_rst_out", 64'(g[31:0]), 64'hF000);
    repeat (6) tick();
    chk("no_stale_resp", 64'(got_q.size()), 64'(nb + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/coreriscv_axi4_alu_arbiter.md
# coreriscv_axi4_alu_arbiter

Two-requester arbiter and sequencer for the shared CoreRISCV AXI4 integer ALU. It accepts operations from the pipeline execute stage (port 0) and the CSR/debug unit (port 1), drives one ALU instance from registered operands, and returns the registered result with a requester tag over a valid/ready response channel. It sits beside the ALU instance in the core and owns every ALU input.

## Interface
- No parameters; datapath width is fixed at 32 bits and the fn encoding is the ALU's 4-bit code.

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req0_valid / req1_valid  in  1  request valid, port 0 / port 1
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_fn / req1_fn  in  4  ALU function code
- req0_dw / req1_dw  in  1  ALU data-width select
- req0_in1 / req1_in1  in  32  operand 1
- req0_in2 / req1_in2  in  32  operand 2
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester of current result (0/1)
- resp_out  out  32  registered ALU io_out
- resp_adder_out  out  32  registered ALU io_adder_out
- resp_cmp_out  out  1  registered ALU io_cmp_out
- alu_fn  out  4, alu_dw  out  1, alu_in1  out  32, alu_in2  out  32  drive to the shared ALU
- alu_out  in  32, alu_adder_out  in  32, alu_cmp_out  in  1  from the shared ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req*_ready follows the grant; on any accepted request, latch fn/dw/in1/in2/id into operand registers, go to EXEC.
- EXEC: alu_* driven from operand registers; ALU outputs captured into resp_* registers at end of cycle; go to RESP.
- RESP: resp_valid=1. If resp_ready=1: a new request may be accepted in the same cycle (ready asserted as in IDLE) -> EXEC; otherwise -> IDLE. If resp_ready=0: hold, no ready asserted, resp_* stable.
- Grant: only one ready asserted per cycle, only to a valid requester. Both valid -> arbitration per Configuration.
- alu_* outputs always equal operand registers (not gated by state); operand registers update only on acceptance.
- fn codes are passed through unchecked; unused codes give whatever the ALU produces.
- Requesters must hold valid and payload stable until accepted; withdrawal before acceptance is a protocol violation (bench asserts).

## Timing
- Accept at edge T -> resp_valid high from cycle T+2 (latency 2).
- Sustained throughput with resp_ready=1: one operation per 2 cycles.
- Reset (reset=0 at an edge): state=IDLE, resp_valid=0, req0_ready=0, req1_ready=0 during reset, resp_id=0, resp_out=0, resp_adder_out=0, resp_cmp_out=0, operand registers=0 (alu_fn=0, alu_dw=0, alu_in1=0, alu_in2=0), round-robin pointer=1 (port 0 wins first tie).
- Reset mid-EXEC or mid-RESP: operation discarded, no response issued.
- Ready is combinational from state, valids and pointer; no combinational path from resp_ready to resp_* data.

## Configuration
- CORERISCV_AXI4_ALU_ARB_RR_EN defined: round-robin; pointer records last granted port, tie goes to the other port; pointer updates only on acceptance.
- Undefined: fixed priority, port 0 always wins a tie; pointer logic removed.

## Test plan
- Port 0 fn=0x0, in1=5, in2=7 -> resp_valid at T+2, resp_out=12, resp_id=0.
- Port 1 fn=0xA, in1=3, in2=5 -> resp_out=0xFFFFFFFE, resp_adder_out=0xFFFFFFFE, resp_id=1.
- Port 0 fn=0xB, in1=0x80000000, in2=4 -> resp_out=0xF8000000; fn=0xC, in1=0xFFFFFFFF, in2=1 -> resp_cmp_out=1, resp_out=1.
- Both ports valid continuously for 4 ops: with RR_EN grants 0,1,0,1; without, 0,0,0,0 and port 1 starved.
- resp_ready held 0 for 5 cycles in RESP -> resp_* stable, both ready=0; resp_ready=1 with req1_valid pending -> req1 accepted same cycle, next resp_valid 2 cycles later.
- reset=0 during EXEC -> next cycle resp_valid=0, all outputs at reset values, no stale response after release.
